// File: rtl/hart_mem_pkg.sv
// Shared types and default widths for the hart memory arbiter.
package hart_mem_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  typedef enum logic       {OWN_I, OWN_D}      owner_e;
endpackage

// File: rtl/hart_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: bit 0 = I, bit 1 = D, one-hot grant.
module rr_arb2
  import hart_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);
  owner_e last_grant;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // on a tie, favour whoever did not win last time
      2'b11:   gnt = (last_grant == OWN_D) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_grant <= OWN_D;
    else if (update && (gnt != 2'b00))
      last_grant <= gnt[1] ? OWN_D : OWN_I;
  end
endmodule

// File: rtl/hart_mem_arbiter.sv
// Shares one memory port between the hart's I and D buses, one transaction
// in flight at a time; responses are routed back to the owning requester.
module hart_mem_arbiter
  import hart_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W/8-1:0] i_wmask,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic                i_rsp_valid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_wmask,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                proto_err
);
  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W/8-1:0] wmask;
    logic [DATA_W-1:0]   wdata;
  } req_t;

  state_e     state;
  owner_e     owner;
  req_t       cap, sel;
  logic [1:0] gnt;
  logic       accept;

  assign accept = (state == IDLE) && (i_req_valid || d_req_valid);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({d_req_valid, i_req_valid}),
    .update (accept),
    .gnt    (gnt)
  );

  assign i_req_ready = accept && gnt[0];
  assign d_req_ready = accept && gnt[1];

  always_comb begin
    if (gnt[1]) sel = '{addr: d_addr, wmask: d_wmask, wdata: d_wdata};
    else        sel = '{addr: i_addr, wmask: i_wmask, wdata: i_wdata};
  end

  assign mem_valid = (state == ISSUE);
  assign mem_addr  = cap.addr;
  assign mem_wmask = cap.wmask;
  assign mem_wdata = cap.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= OWN_I;
      cap         <= '0;
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      proto_err   <= 1'b0;
    end else begin
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      // a response strobe is only legal once the request has been accepted
      if (mem_rvalid && (state != WAIT)) proto_err <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          cap   <= sel;
          owner <= gnt[1] ? OWN_D : OWN_I;
          state <= ISSUE;
        end
        ISSUE: if (mem_ready) state <= WAIT;
        WAIT: if (mem_rvalid) begin
          if (owner == OWN_D) begin
            d_rsp_valid <= 1'b1;
            d_rdata     <= mem_rdata;
          end else begin
            i_rsp_valid <= 1'b1;
            i_rdata     <= mem_rdata;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hart_mem_arbiter.sv
// Directed bench for hart_mem_arbiter with a queue-based scoreboard.
module tb_hart_mem_arbiter;
  logic        clk, rst_n;
  logic        i_req_valid, i_req_ready, i_rsp_valid;
  logic [31:0] i_addr, i_wdata, i_rdata;
  logic [3:0]  i_wmask;
  logic        d_req_valid, d_req_ready, d_rsp_valid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wmask;
  logic        mem_valid, mem_ready, mem_rvalid, proto_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  typedef struct { logic [31:0] addr; logic [3:0] wmask; logic [31:0] wdata; } mem_t;
  typedef struct { bit ds; logic [31:0] data; } rsp_t;
  mem_t exp_mem[$];
  rsp_t exp_rsp[$];
  int checks = 0, failures = 0;

  hart_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_wmask(i_wmask), .i_wdata(i_wdata), .i_rsp_valid(i_rsp_valid), .i_rdata(i_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_wmask(d_wmask), .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: pops expected memory offers and responses as the DUT presents them
  always @(negedge clk) begin
    mem_t m;
    rsp_t r;
    if (rst_n) begin
      if (i_req_ready || d_req_ready) check("ready_onehot", {i_req_ready, d_req_ready} != 2'b11, 1);
      if (mem_valid && mem_ready) begin
        if (exp_mem.size() == 0) begin
          checks++; failures++;
          $display("FAIL mem_unexpected: got addr %0h expected no offer", mem_addr);
        end else begin
          m = exp_mem.pop_front();
          check("mem_addr", mem_addr, m.addr);
          check("mem_wmask", mem_wmask, m.wmask);
          check("mem_wdata", mem_wdata, m.wdata);
        end
      end
      if (i_rsp_valid || d_rsp_valid) begin
        check("rsp_onehot", {i_rsp_valid, d_rsp_valid}, {~d_rsp_valid, d_rsp_valid});
        if (exp_rsp.size() == 0) begin
          checks++; failures++;
          $display("FAIL rsp_unexpected: got i=%0b d=%0b expected none", i_rsp_valid, d_rsp_valid);
        end else begin
          r = exp_rsp.pop_front();
          check("rsp_owner", d_rsp_valid, r.ds);
          check("rsp_data", r.ds ? d_rdata : i_rdata, r.data);
        end
      end
    end
  end

  // one transaction with zero-wait memory; checks grant, cycle-1 offer and cycle-3 response
  task automatic xact(input bit ds, input logic [31:0] a, input logic [3:0] m,
                      input logic [31:0] w, input logic [31:0] rd);
    int n;
    if (ds) begin d_req_valid = 1; d_addr = a; d_wmask = m; d_wdata = w; end
    else    begin i_req_valid = 1; i_addr = a; i_wmask = m; i_wdata = w; end
    #1;
    n = 0;
    while (!(ds ? d_req_ready : i_req_ready) && n < 20) begin tick(); n++; end
    check("grant", ds ? d_req_ready : i_req_ready, 1);
    check("grant_other", ds ? i_req_ready : d_req_ready, 0);
    exp_mem.push_back('{a, m, w});
    exp_rsp.push_back('{ds, rd});
    tick();
    i_req_valid = 0; d_req_valid = 0;
    check("mem_valid_c1", mem_valid, 1);
    mem_ready = 1;
    tick();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = rd;
    tick();
    mem_rvalid = 0;
    check("rsp_c3_own", ds ? d_rsp_valid : i_rsp_valid, 1);
    check("rsp_c3_other", ds ? i_rsp_valid : d_rsp_valid, 0);
    tick();
    check("rsp_single", ds ? d_rsp_valid : i_rsp_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {i_req_ready, d_req_ready}, 0);
    check({tag, "_rsp"}, {i_rsp_valid, d_rsp_valid}, 0);
    check({tag, "_mem"}, {mem_valid, mem_wmask, mem_addr, mem_wdata}, 0);
    check({tag, "_rdata"}, {i_rdata, d_rdata}, 0);
    check({tag, "_proto"}, proto_err, 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    i_req_valid = 0; i_addr = 0; i_wmask = 0; i_wdata = 0;
    d_req_valid = 0; d_addr = 0; d_wmask = 0; d_wdata = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1;
    tick();

    // single read from I, then D write
    xact(0, 32'h100, 4'h0, 32'h0, 32'hDEADBEEF);
    check("i_rdata_read", i_rdata, 32'hDEADBEEF);
    xact(1, 32'h200, 4'hF, 32'h12345678, 32'hCAFEF00D);
    check("d_rdata_write", d_rdata, 32'hCAFEF00D);

    // contention: both valid throughout, expect I, D, I, D
    i_req_valid = 1; i_addr = 32'h1000; i_wmask = 0; i_wdata = 0;
    d_req_valid = 1; d_addr = 32'h2000; d_wmask = 0; d_wdata = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("tie_i_ready", i_req_ready, (k % 2) == 0);
      check("tie_d_ready", d_req_ready, (k % 2) == 1);
      exp_mem.push_back('{(k % 2) ? 32'h2000 : 32'h1000, 4'h0, 32'h0});
      exp_rsp.push_back('{(k % 2) == 1, 32'hA0 + k});
      tick();
      mem_ready = 1;
      tick();
      mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hA0 + k;
      tick();
      mem_rvalid = 0;
    end
    i_req_valid = 0; d_req_valid = 0;
    tick();
    check("proto_clean", proto_err, 0);

    // stall: memory withholds ready for 5 cycles while I keeps asking
    d_req_valid = 1; d_addr = 32'h300; d_wmask = 0; d_wdata = 0;
    #1;
    check("stall_grant", d_req_ready, 1);
    exp_mem.push_back('{32'h300, 4'h0, 32'h0});
    exp_rsp.push_back('{1, 32'h55AA55AA});
    tick();
    d_req_valid = 0; i_req_valid = 1; i_addr = 32'h500;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_valid", mem_valid, 1);
      check("stall_addr", mem_addr, 32'h300);
      check("stall_no_ready", i_req_ready, 0);
      tick();
    end
    i_req_valid = 0; mem_ready = 1;
    tick();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h55AA55AA;
    tick();
    mem_rvalid = 0;
    check("stall_rsp", d_rsp_valid, 1);
    tick();
    check("i_rdata_hold", i_rdata, 32'hA2);
    check("d_rdata_stall", d_rdata, 32'h55AA55AA);

    // stray response strobe while idle
    mem_rvalid = 1; mem_rdata = 32'hBAD0;
    tick();
    mem_rvalid = 0;
    check("proto_set", proto_err, 1);
    check("proto_no_rsp", {i_rsp_valid, d_rsp_valid}, 0);
    tick(); tick(); tick();
    check("proto_sticky", proto_err, 1);

    // reset while waiting on an I read; the late response is dropped
    i_req_valid = 1; i_addr = 32'h400; i_wmask = 0;
    #1;
    check("abort_grant", i_req_ready, 1);
    exp_mem.push_back('{32'h400, 4'h0, 32'h0});
    tick();
    i_req_valid = 0; mem_ready = 1;
    tick();
    mem_ready = 0;
    rst_n = 0;
    tick();
    mem_rvalid = 1; mem_rdata = 32'hBAD1;
    tick();
    mem_rvalid = 0;
    tick();
    rst_n = 1;
    tick();
    check_reset_outputs("post_reset");

    // first tie after reset goes to I; rvalid alongside mem_ready is an error
    i_req_valid = 1; i_addr = 32'h600; d_req_valid = 1; d_addr = 32'h700;
    #1;
    check("reset_tie_i", i_req_ready, 1);
    check("reset_tie_d", d_req_ready, 0);
    exp_mem.push_back('{32'h600, 4'h0, 32'h0});
    exp_rsp.push_back('{0, 32'h77});
    tick();
    i_req_valid = 0; d_req_valid = 0;
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'hEE;
    tick();
    mem_ready = 0; mem_rvalid = 0;
    check("early_rvalid_err", proto_err, 1);
    check("early_rvalid_no_rsp", {i_rsp_valid, d_rsp_valid}, 0);
    check("early_rvalid_wait", mem_valid, 0);
    tick();
    mem_rvalid = 1; mem_rdata = 32'h77;
    tick();
    mem_rvalid = 0;
    check("late_rsp", i_rsp_valid, 1);
    tick(); tick();

    check("mem_queue_empty", exp_mem.size(), 0);
    check("rsp_queue_empty", exp_rsp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
